// File: rtl/osd_pkg.sv
// -----------------------------------------------------------------------------
// osd_pkg
// Shared constants and helpers for the OSD text overlay path.
//   RGB_W     : pixel colour width (RGB888)
//   GLYPH_W/H : glyph cell size in pixels / lines
//   CHAR_W    : stored character code width (7-bit ASCII)
//   CNT_W     : pixel / line counter width
//   OSD_LAT   : fixed video latency through osd_char_render, in clock edges
//   rom_addr_of() : glyph ROM address = {char code, glyph row}
// -----------------------------------------------------------------------------
package osd_pkg;

    localparam int RGB_W   = 24;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int CHAR_W  = 7;
    localparam int GROW_W  = 4;
    localparam int CNT_W   = 12;
    localparam int OSD_LAT = 4;

    function automatic logic [CHAR_W+GROW_W-1:0] rom_addr_of(
        input logic [CHAR_W-1:0] ch,
        input logic [GROW_W-1:0] grow
    );
        return {ch, grow};
    endfunction

endpackage

// File: rtl/osd_text_buf.sv
// -----------------------------------------------------------------------------
// osd_text_buf
// Character cell storage for the OSD window: one write port from the command
// side and one synchronous read port for the video side. A read and a write to
// the same cell on the same edge returns the previous contents.
// Ports:
//   clk   : pixel clock
//   we    : write strobe
//   waddr : write cell address {row, col}
//   wdata : ASCII code to store
//   raddr : read cell address {row, col}
//   rdata : registered character code (one edge after raddr)
// -----------------------------------------------------------------------------
module osd_text_buf
    import osd_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [CHAR_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [CHAR_W-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [CHAR_W-1:0] mem [DEPTH];

    // Contents are never reset; cells are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/osd_char_render.sv
// -----------------------------------------------------------------------------
// osd_char_render
// Tracks the pixel position of the incoming video, looks up the character
// under each pixel in the text buffer, fetches the glyph row from the external
// ascii_char_rom and paints foreground pixels over the video. Timing signals
// and video travel through a fixed 4-edge pipeline regardless of the window.
//
// Optional build macro OSD_BG_BLEND_EN: when defined, in-window background
// pixels are output at half intensity per channel; otherwise they pass through.
//
// Ports:
//   clk, rst_n                  : pixel clock, asynchronous active-low reset
//   osd_en                      : overlay enable, sampled with each pixel
//   osd_x, osd_y                : window top-left corner (pixels, lines)
//   txt_we/txt_waddr/txt_wdata  : text buffer write port, address {row, col}
//   vin_de/vin_hs/vin_vs/vin_data : input video
//   rom_addr / rom_data         : glyph ROM interface, {char, glyph_row} / row bits
//   vout_de/vout_hs/vout_vs/vout_data : delayed, overlaid video
// -----------------------------------------------------------------------------
module osd_char_render
    import osd_pkg::*;
#(
    parameter int          COLS     = 32,
    parameter int          ROWS     = 4,
    parameter int          GLYPH_W  = osd_pkg::GLYPH_W,
    parameter int          GLYPH_H  = osd_pkg::GLYPH_H,
    parameter int          ROM_AW   = 11,
    parameter int          ROM_DW   = 9,
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         osd_en,
    input  logic [11:0]                  osd_x,
    input  logic [11:0]                  osd_y,
    input  logic                         txt_we,
    input  logic [$clog2(COLS*ROWS)-1:0] txt_waddr,
    input  logic [6:0]                   txt_wdata,
    input  logic                         vin_de,
    input  logic                         vin_hs,
    input  logic                         vin_vs,
    input  logic [23:0]                  vin_data,
    output logic [ROM_AW-1:0]            rom_addr,
    input  logic [ROM_DW-1:0]            rom_data,
    output logic                         vout_de,
    output logic                         vout_hs,
    output logic                         vout_vs,
    output logic [23:0]                  vout_data
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int TA_W  = COL_W + ROW_W;

    localparam logic [CNT_W-1:0] WIN_W = CNT_W'(COLS * GLYPH_W);
    localparam logic [CNT_W-1:0] WIN_H = CNT_W'(ROWS * GLYPH_H);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef OSD_BG_BLEND_EN
    function automatic logic [RGB_W-1:0] half_rgb(input logic [RGB_W-1:0] c);
        return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
    endfunction
`endif

    logic [CNT_W-1:0] x_cnt;
    logic [CNT_W-1:0] y_cnt;
    logic [CNT_W-1:0] rel_x;
    logic [CNT_W-1:0] rel_y;
    logic             in_win;
    logic             de_fall;
    logic             vs_rise;

    logic [TA_W-1:0]   raddr_p0;
    logic [2:0]        pcol_p0, pcol_p1, pcol_p2, pcol_p3;
    logic [3:0]        grow_p0, grow_p1;
    logic              win_p0, win_p1, win_p2, win_p3;
    logic [RGB_W-1:0]  rgb_p0, rgb_p1, rgb_p2, rgb_p3;
    logic              vld_p0, vld_p1, vld_p2, vld_p3;
    logic              hs_p0, hs_p1, hs_p2, hs_p3;
    logic              vs_p0, vs_p1, vs_p2, vs_p3;
    logic [CHAR_W-1:0] char_p1;

    logic [7:0]        glyph;
    logic [2:0]        bit_idx;
    logic              fg_hit;
    logic [RGB_W-1:0]  bg_rgb;
    logic [ROM_DW-9:0] unused_rom_bits;

    // vld_p0 / vs_p0 hold the previous input sample, so they double as edge history.
    assign de_fall = vld_p0 & ~vin_de;
    assign vs_rise = vin_vs & ~vs_p0;

    // Unsigned wrap makes pixels left of / above the window compare as huge.
    assign rel_x  = x_cnt - osd_x;
    assign rel_y  = y_cnt - osd_y;
    assign in_win = osd_en && (rel_x < WIN_W) && (rel_y < WIN_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (vin_de) begin
                x_cnt <= sat_inc(x_cnt);
            end else if (de_fall) begin
                x_cnt <= '0;
            end
            if (vs_rise) begin
                y_cnt <= '0;
            end else if (de_fall) begin
                y_cnt <= sat_inc(y_cnt);
            end
        end
    end

    osd_text_buf #(
        .AW(TA_W)
    ) u_text_buf (
        .clk  (clk),
        .we   (txt_we),
        .waddr(txt_waddr),
        .wdata(txt_wdata),
        .raddr(raddr_p0),
        .rdata(char_p1)
    );

    assign glyph           = rom_data[7:0];
    assign unused_rom_bits = rom_data[ROM_DW-1:8];
    assign bit_idx         = 3'd7 - pcol_p3;
    assign fg_hit          = win_p3 && glyph[bit_idx];

`ifdef OSD_BG_BLEND_EN
    assign bg_rgb = win_p3 ? half_rgb(rgb_p3) : rgb_p3;
`else
    assign bg_rgb = rgb_p3;
`endif

    // The whole video pipeline is cleared so nothing stale leaks out after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_p0  <= '0;
            pcol_p0   <= '0;
            grow_p0   <= '0;
            win_p0    <= 1'b0;
            rgb_p0    <= '0;
            vld_p0    <= 1'b0;
            hs_p0     <= 1'b0;
            vs_p0     <= 1'b0;
            pcol_p1   <= '0;
            grow_p1   <= '0;
            win_p1    <= 1'b0;
            rgb_p1    <= '0;
            vld_p1    <= 1'b0;
            hs_p1     <= 1'b0;
            vs_p1     <= 1'b0;
            rom_addr  <= '0;
            pcol_p2   <= '0;
            win_p2    <= 1'b0;
            rgb_p2    <= '0;
            vld_p2    <= 1'b0;
            hs_p2     <= 1'b0;
            vs_p2     <= 1'b0;
            pcol_p3   <= '0;
            win_p3    <= 1'b0;
            rgb_p3    <= '0;
            vld_p3    <= 1'b0;
            hs_p3     <= 1'b0;
            vs_p3     <= 1'b0;
            vout_de   <= 1'b0;
            vout_hs   <= 1'b0;
            vout_vs   <= 1'b0;
            vout_data <= '0;
        end else begin
            // ---- p0: sample input, split position into cell / glyph coordinates
            raddr_p0 <= {rel_y[4 +: ROW_W], rel_x[3 +: COL_W]};
            pcol_p0  <= rel_x[2:0];
            grow_p0  <= rel_y[3:0];
            win_p0   <= in_win;
            rgb_p0   <= vin_data;
            vld_p0   <= vin_de;
            hs_p0    <= vin_hs;
            vs_p0    <= vin_vs;
            // ---- p1: text buffer returns the character code
            pcol_p1  <= pcol_p0;
            grow_p1  <= grow_p0;
            win_p1   <= win_p0;
            rgb_p1   <= rgb_p0;
            vld_p1   <= vld_p0;
            hs_p1    <= hs_p0;
            vs_p1    <= vs_p0;
            // ---- p2: glyph ROM address; held outside the window to avoid toggling
            if (win_p1) begin
                rom_addr <= ROM_AW'(rom_addr_of(char_p1, grow_p1));
            end
            pcol_p2  <= pcol_p1;
            win_p2   <= win_p1;
            rgb_p2   <= rgb_p1;
            vld_p2   <= vld_p1;
            hs_p2    <= hs_p1;
            vs_p2    <= vs_p1;
            // ---- p3: ROM samples the address; its data is valid before the next edge
            pcol_p3  <= pcol_p2;
            win_p3   <= win_p2;
            rgb_p3   <= rgb_p2;
            vld_p3   <= vld_p2;
            hs_p3    <= hs_p2;
            vs_p3    <= vs_p2;
            // ---- output: pick glyph pixel or video
            vout_de   <= vld_p3;
            vout_hs   <= hs_p3;
            vout_vs   <= vs_p3;
            vout_data <= fg_hit ? FG_COLOR : bg_rgb;
        end
    end

endmodule

// File: doc/osd_char_render.md
Name: osd_char_render

Overview:
- Video-path stage directly upstream of ascii_char_rom and the consumer of its glyph data in the udp_osd design.
- Tracks pixel position from incoming de/hs/vs and holds a COLS x ROWS text buffer written from the UDP command side.
- Issues glyph-row addresses to ascii_char_rom and overlays foreground pixels on the video stream; sync signals are delayed to match.

Parameters:
- COLS, 32, text columns; power of 2.
- ROWS, 4, text rows; power of 2.
- GLYPH_W, 8, glyph width in pixels; fixed 8.
- GLYPH_H, 16, glyph height in rows; fixed 16.
- ROM_AW, 11, ROM address width: {char[6:0], glyph_row[3:0]}.
- ROM_DW, 9, ROM data width; bits [7:0] are used, MSB = leftmost pixel, bit 8 is ignored.
- FG_COLOR, 24'hFFFFFF, RGB888 foreground colour.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- osd_en  in  1  overlay enable; sampled per pixel.
- osd_x  in  12  window left edge, in pixels.
- osd_y  in  12  window top edge, in lines.
- txt_we  in  1  text buffer write strobe.
- txt_waddr  in  log2(COLS*ROWS)  write address, {row, col}.
- txt_wdata  in  7  ASCII code.
- vin_de / vin_hs / vin_vs  in  1 each  input video timing.
- vin_data  in  24  input RGB888.
- rom_addr  out  ROM_AW  address to ascii_char_rom.
- rom_data  in  ROM_DW  data from ascii_char_rom.
- vout_de / vout_hs / vout_vs  out  1 each  delayed timing.
- vout_data  out  24  overlaid RGB888.

Behaviour:
- Clocking and reset: one clock, clk. Asynchronous active-low reset, rst_n.
- Reset values: all outputs 0 and counters 0. Text buffer contents are not reset and are undefined until written.
- Position counters:
  - x_cnt increments on each vin_de=1 cycle and clears on the cycle after the falling edge of de.
  - y_cnt increments on the de falling edge and clears on the vs rising edge.
  - Both are 12-bit and saturate at 4095.
- Window test: in_win = osd_en && x_cnt-osd_x < COLS*8 && y_cnt-osd_y < ROWS*16. Subtractions are unsigned 12-bit, so x below osd_x wraps large and falls outside.
- Coordinate split: rel_x[2:0] = pixel column, rel_x[2+log2(COLS):3] = char column, rel_y[3:0] = glyph row, rel_y[3+log2(ROWS):4] = text row.
- Pipeline, with edges counted from the edge E0 that samples the vin_* inputs:
  - E1: text buffer synchronous read registers char code; col, glyph row, in_win and video are registered.
  - E2: rom_addr <= {char[6:0], glyph_row}; held while not in_win.
  - E3: ROM samples the address; rom_data is valid before E4 (1-cycle ROM, no output register).
  - E4: pixel bit = rom_data[7-col]. vout_data = FG_COLOR if (bit && in_win_d), else the delayed vin_data.
- Latency: fixed 4 cycles for de, hs, vs and data, both inside and outside the window.
- Text write/read collision: a write and a read to the same address in the same cycle returns the old value; the new value is visible from the next cycle.
- osd_en change mid-frame takes effect per pixel after 4 cycles.
- rst_n asserted mid-line: outputs go to 0 immediately; the pipeline flushes and no stale pixels appear after release.

Optional Feature:
- Macro: OSD_BG_BLEND_EN.
- Defined: in-window background pixels (bit=0) output each channel >>1 (half intensity).
- Undefined: background pixels pass through unmodified.

Decomposition:
- Package osd_pkg holds:
  - RGB width (24) and the glyph constants GLYPH_W and GLYPH_H.
  - The ROM address composition rule.
  - Pipeline latency localparam OSD_LAT = 4.
- One sub-module, osd_text_buf: COLS*ROWS x 7 dual-port, one write port and one synchronous read port, register-inferred.

Test Plan:
- Reset: hold rst_n=0 with random video -> all vout_* = 0. After release, vout_de equals vin_de delayed exactly 4 cycles.
- Text write: osd_x=100, osd_y=50, write 'A' (0x41) at addr 0. Pixel (100,50) -> rom_addr = 0x410 asserted 2 cycles after sampling. vout_data matches the glyph bit pattern of rom_data[7:0] from 4 cycles after sampling.
- Window edges: x = 99, 100, 355, 356 on line 50 -> only 100 and 355 can be overlaid. x < osd_x wraparound gives no overlay.
- osd_en=0: full frame -> vout_data equals vin_data delayed 4 cycles. rom_addr does not affect output.
- Write/read collision: write 'B' to addr 5 while that cell is being read -> old char shown that cycle, 'B' on the next read.
- OSD_BG_BLEND_EN: background pixel 0x80FF40 in window -> 0x407F20; outside window unchanged. Without the macro -> 0x80FF40.
